bus_responder: RTL

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_responder_pkg.sv | 30 +++
 rtl/sp_ram_be.sv | 26 ++
 rtl/bus_responder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bus_responder_pkg.sv
// Shared definitions for the bus responder: address map, FSM encoding and
// byte-strobe merge helper.
package bus_responder_pkg;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
    localparam logic [31:0] TOGGLE_ADDR = MMIO_BASE + 32'h0;
    localparam logic [31:0] TIMER_ADDR  = MMIO_BASE + 32'h4;
    localparam logic [31:0] CMP_ADDR    = MMIO_BASE + 32'h8;
    localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'hC;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    typedef enum logic {
        StIdle = 1'b0,
        StResp = 1'b1
    } state_e;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sp_ram_be.sv
// Single-port RAM with per-byte write enables and a registered read port.
module sp_ram_be #(
    parameter int unsigned WORDS = 1024,
    localparam int unsigned AW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // Read returns the pre-write contents; contents are never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_responder.sv
// Single-outstanding bus slave: byte-enabled RAM plus TOGGLE/TIMER/CMP/STATUS
// registers, one-cycle response after each accepted request.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] toggle_value,
    output logic        timer_irq
);

    localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    state_e      state_q;
    logic [31:0] toggle_q, timer_q, cmp_q;
    logic        status_q;
    logic        err_q, ram_rd_q;
    logic [31:0] rdata_q;
    logic [31:0] ram_rdata;

    logic        handshake, misaligned, acc_err, wr_ok, status_clr, match;
    logic        sel_ram, sel_toggle, sel_timer, sel_cmp, sel_status;
    logic [31:0] reg_rdata;

    assign req_ready = resetn && (state_q == StIdle);
    assign handshake = req_valid && req_ready;

    // RAM_BASE is zero, so an upper bound alone selects the RAM window.
    assign sel_ram    = ({1'b0, req_addr} < RAM_BYTES);
    assign sel_toggle = (req_addr == TOGGLE_ADDR);
    assign sel_timer  = (req_addr == TIMER_ADDR);
    assign sel_cmp    = (req_addr == CMP_ADDR);
    assign sel_status = (req_addr == STATUS_ADDR);
    assign misaligned = |req_addr[1:0];

    assign acc_err = misaligned
                   || !(sel_ram || sel_toggle || sel_timer || sel_cmp || sel_status)
                   || (req_we && sel_timer);
    assign wr_ok      = handshake && req_we && !acc_err;
    assign status_clr = wr_ok && sel_status && req_wstrb[0] && req_wdata[0];
    assign match      = (timer_q == cmp_q);

    always_comb begin
        reg_rdata = 32'h0;
        if (sel_toggle)      reg_rdata = toggle_q;
        else if (sel_timer)  reg_rdata = timer_q;
        else if (sel_cmp)    reg_rdata = cmp_q;
        else if (sel_status) reg_rdata = {31'h0, status_q};
    end

    sp_ram_be #(
        .WORDS (RAM_WORDS)
    ) u_ram (
        .clk   (clk),
        .en    (handshake && sel_ram && !acc_err),
        .we    ((wr_ok && sel_ram) ? req_wstrb : 4'h0),
        .addr  (req_addr[AW+1:2]),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            toggle_q <= 32'h0;
            timer_q  <= 32'h0;
            cmp_q    <= CMP_RESET;
            status_q <= 1'b0;
            err_q    <= 1'b0;
            ram_rd_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            timer_q <= timer_q + 32'd1;

            // A match on the same edge as a write-1-clear keeps the flag set.
            if (match)           status_q <= 1'b1;
            else if (status_clr) status_q <= 1'b0;

            if (wr_ok && sel_toggle) toggle_q <= apply_wstrb(toggle_q, req_wdata, req_wstrb);
            if (wr_ok && sel_cmp)    cmp_q    <= apply_wstrb(cmp_q, req_wdata, req_wstrb);

            unique case (state_q)
                StIdle: begin
                    if (handshake) begin
                        state_q  <= StResp;
                        err_q    <= acc_err;
                        ram_rd_q <= sel_ram && !req_we && !acc_err;
                        rdata_q  <= (req_we || acc_err) ? 32'h0 : reg_rdata;
                    end
                end
                StResp: begin
                    state_q  <= StIdle;
                    err_q    <= 1'b0;
                    ram_rd_q <= 1'b0;
                    rdata_q  <= 32'h0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid    = (state_q == StResp);
    assign rsp_err      = err_q;
    assign rsp_rdata    = ram_rd_q ? ram_rdata : rdata_q;
    assign toggle_value = toggle_q;
    assign timer_irq    = status_q;

endmodule
